// File: rtl/intersection_phase_arbiter.sv
// ---------------------------------------------------------------------------
// intersection_phase_arbiter
//
// Purpose: gives right-of-way at a 4-approach junction. Only one approach is
// green at a time. Requests are latched per approach and served round-robin.
// Each normal green has a minimum length, then yields to a competing request
// through yellow and an all-red clearance. An emergency request preempts
// toward a selected approach.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset (all-red, pending lost)
//   req_i[3:0]    per-approach request level, bit i = approach i
//   emg_req_i     emergency preemption request level
//   emg_dir_i     approach that receives the emergency green
//   green_o       green lamp per approach (one-hot or zero)
//   yellow_o      yellow lamp per approach (one-hot or zero)
//   red_o         red lamp per approach, ~(green | yellow)
//   grant_id_o    approach currently or most recently granted
//   pending_o     latched, not yet served requests
//   emg_active_o  high while the emergency green is held
// ---------------------------------------------------------------------------
module intersection_phase_arbiter #(
  parameter int unsigned CW          = 6,
  parameter int unsigned T_MIN_GREEN = 10,
  parameter int unsigned T_MAX_GREEN = 30,
  parameter int unsigned T_YELLOW    = 5,
  parameter int unsigned T_ALLRED    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic       emg_req_i,
  input  logic [1:0] emg_dir_i,
  output logic [3:0] green_o,
  output logic [3:0] yellow_o,
  output logic [3:0] red_o,
  output logic [1:0] grant_id_o,
  output logic [3:0] pending_o,
  output logic       emg_active_o
);

  typedef enum logic [1:0] {
    ST_ALLRED    = 2'd0,
    ST_GREEN     = 2'd1,
    ST_YELLOW    = 2'd2,
    ST_EMG_GREEN = 2'd3
  } state_e;

  localparam logic [CW-1:0] MinGreen = CW'(T_MIN_GREEN);
  localparam logic [CW-1:0] MaxGreen = CW'(T_MAX_GREEN);
  localparam logic [CW-1:0] Yellow   = CW'(T_YELLOW);
  localparam logic [CW-1:0] AllRed   = CW'(T_ALLRED);
  localparam logic [CW-1:0] TimerOne = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [3:0]    pending_q, pending_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;

  logic [3:0]    grant_oh;
  logic [3:0]    lit_mask;
  logic [3:0]    clear_mask;
  logic          competing;
  logic          allred_done;
  logic          rr_found;
  logic [1:0]    rr_winner;

  assign grant_oh    = 4'b0001 << grant_q;
  // The lit approach's own request is not latched, and is never "competing".
  assign lit_mask    = (state_q == ST_ALLRED) ? 4'b0000 : grant_oh;
  assign competing   = |(pending_q & ~lit_mask);
  assign allred_done = (timer_q >= AllRed);

  // Round-robin search: first pending bit from rr_ptr+1 upward, wrapping.
  // The 2-bit sum wraps naturally modulo 4.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = rr_ptr_q;
    for (int i = 1; i <= 4; i++) begin
      if (!rr_found && pending_q[rr_ptr_q + 2'(i)]) begin
        rr_found  = 1'b1;
        rr_winner = rr_ptr_q + 2'(i);
      end
    end
  end

  // Next-state logic. Emergency is always checked before normal requests.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    clear_mask = 4'b0000;
    case (state_q)
      ST_ALLRED: begin
        if (allred_done && emg_req_i) begin
          state_d = ST_EMG_GREEN;
          grant_d = emg_dir_i;
        end else if (allred_done && rr_found) begin
          state_d = ST_GREEN;
          grant_d = rr_winner;
        end
      end
      ST_GREEN: begin
        if (emg_req_i && (emg_dir_i != grant_q)) begin
          state_d = ST_YELLOW;
        end else if (emg_req_i) begin
          state_d = ST_EMG_GREEN;
        end else if (competing && (timer_q >= MinGreen)) begin
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (timer_q == Yellow) begin
          state_d = ST_ALLRED;
        end
      end
      ST_EMG_GREEN: begin
        if (!emg_req_i) begin
          state_d = ST_YELLOW;
        end
      end
      default: state_d = ST_ALLRED;
    endcase

    // Entering any green phase serves that approach: clear its pending bit
    // and move the round-robin pointer onto it.
    if ((state_d != state_q) &&
        ((state_d == ST_GREEN) || (state_d == ST_EMG_GREEN))) begin
      clear_mask = 4'b0001 << grant_d;
      rr_ptr_d   = grant_d;
    end
  end

  // Phase timer: restarts at 1 on each state change. Saturation keeps idle
  // all-red, resting green and long emergency holds from wrapping.
  always_comb begin
    timer_d = timer_q + TimerOne;
    if (state_d != state_q) begin
      timer_d = TimerOne;
    end else begin
      case (state_q)
        ST_GREEN:     if (timer_q >= MaxGreen) timer_d = MaxGreen;
        ST_ALLRED:    if (timer_q >= AllRed)   timer_d = AllRed;
        ST_EMG_GREEN: if (&timer_q)            timer_d = timer_q;
        default:      timer_d = timer_q + TimerOne;
      endcase
    end
  end

  // Clear has priority over a same-cycle set.
  assign pending_d = (pending_q | (req_i & ~lit_mask)) & ~clear_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ALLRED;
      timer_q   <= TimerOne;
      pending_q <= 4'b0000;
      grant_q   <= 2'd0;
      rr_ptr_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Lamps decode from registered state only.
  always_comb begin
    green_o  = 4'b0000;
    yellow_o = 4'b0000;
    if ((state_q == ST_GREEN) || (state_q == ST_EMG_GREEN)) begin
      green_o = grant_oh;
    end
    if (state_q == ST_YELLOW) begin
      yellow_o = grant_oh;
    end
  end

  assign red_o        = ~(green_o | yellow_o);
  assign grant_id_o   = grant_q;
  assign pending_o    = pending_q;
  assign emg_active_o = (state_q == ST_EMG_GREEN);

endmodule
